// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter and its rotate-priority picker.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DFLT   = 4;
    localparam int unsigned BURST_MAX_DFLT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2 for elaboration-time width calculation; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotate-priority encoder: first set bit of req searching upward from ptr, wrapping modulo N.
module fifo_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] index
);

    logic [2*N-1:0] rot;

    // Rotate so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot   = {req, req} >> ptr;
        any   = |req;
        index = '0;
        for (int unsigned j = N; j > 0; j--) begin
            if (rot[j-1]) index = IW'((32'(ptr) + j - 1) % N);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter muxing NUM_REQ producers onto one sync FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DFLT,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_MAX  = BURST_MAX_DFLT,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_req,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [ID_WIDTH-1:0]           fifo_wr_id,
    output logic                          busy
);

    localparam int unsigned BW = clog2(BURST_MAX) + 1;

    arb_state_e            state, state_nxt;
    logic [ID_WIDTH-1:0]   owner, owner_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [BW-1:0]         beat_cnt, beat_cnt_nxt;
    logic [DATA_WIDTH-1:0] data_hold;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  owner_valid;
    logic                  pick_any;
    logic                  xfer;

    fifo_rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .any   (pick_any),
        .index (pick_idx)
    );

    // Select the current owner's valid bit and data word.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner == ID_WIDTH'(k)) begin
                owner_valid = req_valid[k];
                owner_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        busy         = 1'b0;
        req_ready    = '0;
        xfer         = 1'b0;
        fifo_wr_req  = 1'b0;
        fifo_wr_data = data_hold;
        fifo_wr_id   = owner;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy         = 1'b1;
                req_ready    = fifo_full ? '0 : (NUM_REQ'(1) << owner);
                xfer         = owner_valid & ~fifo_full;
                fifo_wr_req  = xfer;
                fifo_wr_data = owner_data;
                if (xfer) beat_cnt_nxt = beat_cnt + 1'b1;
                // A stalled owner (fifo_full) keeps the grant; only a dropped valid or the last beat releases.
                if (!owner_valid || (xfer && beat_cnt == BW'(BURST_MAX - 1))) begin
                    state_nxt    = ST_IDLE;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            data_hold <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            beat_cnt  <= beat_cnt_nxt;
            data_hold <= fifo_wr_data;
        end
    end

endmodule
